design2_wrapper: RTL and testbench

Single-frame AXI-Stream capture/replay buffer for the radar channel-1 data path. It accepts samples on a slave AXI-Stream into internal memory until the frame is full or tlast is seen. It holds the frame until the channel-1 transmitter signals completion, then replays the frame on a master AXI-Stream with tlast on the final word, and re-arms for the next capture.

---
 rtl/design2_wrapper.sv | 132 +++++++++++++
 tb/tb_design2_wrapper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/design2_wrapper.sv
// Single-frame AXI-Stream capture/replay buffer for radar channel 1.
// Captures one frame, waits for the tx-done trigger, then replays it.
module design2_wrapper #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int DEPTH                = 512
) (
   input  logic                                axis_aclk,
   input  logic                                axis_aresetn,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_tdata,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_tstrb,
   input  logic                                S_AXIS_tlast,
   input  logic                                S_AXIS_tvalid,
   output logic                                S_AXIS_tready,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0]     M_AXIS_tdata,
   output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_tstrb,
   output logic                                M_AXIS_tlast,
   output logic                                M_AXIS_tvalid,
   input  logic                                M_AXIS_tready,
   input  logic                                ch1_tx_done
);

   localparam int DW = C_S_AXIS_TDATA_WIDTH;
   localparam int IW = $clog2(DEPTH);
   localparam int AW = IW + 1;

   typedef enum logic [1:0] {
      FILL,
      WAIT_TRIG,
      PREFETCH,
      DRAIN
   } state_t;

   state_t          state;
   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [AW-1:0]   len;
   logic            trig_pend;
   logic            tx_done_d;

   logic            s_fire;
   logic            m_fire;
   logic            trig_rise;
   logic            last_wr;
   logic            unused_tstrb;

   assign s_fire    = (state == FILL) && S_AXIS_tvalid && S_AXIS_tready;
   assign m_fire    = M_AXIS_tvalid && M_AXIS_tready;
   assign trig_rise = ch1_tx_done && !tx_done_d;
   assign last_wr   = (wptr == AW'(DEPTH - 1));

   // Input byte strobes carry no information for this path.
   assign unused_tstrb = ^S_AXIS_tstrb;
   assign M_AXIS_tstrb = '1;

   // Frame storage: plain write port, no reset on the array.
   always_ff @(posedge axis_aclk) begin
      if (s_fire)
         mem[wptr[IW-1:0]] <= S_AXIS_tdata;
   end

   // Control FSM with registered stream outputs and trigger edge capture.
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state         <= FILL;
         wptr          <= '0;
         rptr          <= '0;
         len           <= '0;
         trig_pend     <= 1'b0;
         tx_done_d     <= 1'b0;
         S_AXIS_tready <= 1'b0;
         M_AXIS_tvalid <= 1'b0;
         M_AXIS_tlast  <= 1'b0;
         M_AXIS_tdata  <= '0;
      end else begin
         tx_done_d <= ch1_tx_done;
         if (trig_rise)
            trig_pend <= 1'b1;

         case (state)
            FILL: begin
               S_AXIS_tready <= 1'b1;
               if (s_fire) begin
                  wptr <= wptr + AW'(1);
                  if (S_AXIS_tlast || last_wr) begin
                     len           <= wptr + AW'(1);
                     S_AXIS_tready <= 1'b0;
                     state         <= WAIT_TRIG;
                  end
               end
            end

            WAIT_TRIG: begin
               S_AXIS_tready <= 1'b0;
               if (trig_pend) begin
                  // A fresh edge in this very cycle is kept for the next frame.
                  trig_pend <= trig_rise;
                  state     <= PREFETCH;
               end
            end

            PREFETCH: begin
               M_AXIS_tdata  <= mem[0];
               M_AXIS_tvalid <= 1'b1;
               M_AXIS_tlast  <= (len == AW'(1));
               rptr          <= AW'(1);
               state         <= DRAIN;
            end

            DRAIN: begin
               if (m_fire) begin
                  if (M_AXIS_tlast) begin
                     M_AXIS_tvalid <= 1'b0;
                     M_AXIS_tlast  <= 1'b0;
                     wptr          <= '0;
                     rptr          <= '0;
                     S_AXIS_tready <= 1'b1;
                     state         <= FILL;
                  end else begin
                     M_AXIS_tdata <= mem[rptr[IW-1:0]];
                     M_AXIS_tlast <= (rptr == len - AW'(1));
                     rptr         <= rptr + AW'(1);
                  end
               end
            end

            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_design2_wrapper.sv
// Directed self-checking bench for design2_wrapper.
// Covers reset, full and short frames, triggering, backpressure, mid-drain reset.
module tb_design2_wrapper;

   localparam int DW    = 32;
   localparam int DEPTH = 512;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DW-1:0]   s_tdata;
   logic [3:0]      s_tstrb;
   logic            s_tlast;
   logic            s_tvalid;
   logic            s_tready;
   logic [DW-1:0]   m_tdata;
   logic [3:0]      m_tstrb;
   logic            m_tlast;
   logic            m_tvalid;
   logic            m_tready;
   logic            ch1_tx_done;

   int n_cmp = 0;
   int n_err = 0;

   design2_wrapper #(
      .C_S_AXIS_TDATA_WIDTH(DW),
      .DEPTH(DEPTH)
   ) dut (
      .axis_aclk    (clk),
      .axis_aresetn (rst_n),
      .S_AXIS_tdata (s_tdata),
      .S_AXIS_tstrb (s_tstrb),
      .S_AXIS_tlast (s_tlast),
      .S_AXIS_tvalid(s_tvalid),
      .S_AXIS_tready(s_tready),
      .M_AXIS_tdata (m_tdata),
      .M_AXIS_tstrb (m_tstrb),
      .M_AXIS_tlast (m_tlast),
      .M_AXIS_tvalid(m_tvalid),
      .M_AXIS_tready(m_tready),
      .ch1_tx_done  (ch1_tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Push n words (index or constant data); optional tlast and trigger pulse.
   task automatic fill(input int n, input bit incr, input bit tl,
                       input int pulse_at);
      int i   = 0;
      int cyc = 0;
      while (i < n && cyc < 4 * DEPTH) begin
         s_tvalid = 1'b1;
         s_tdata  = incr ? 32'(i) : 32'habcdef01;
         s_tlast  = tl && (i == n - 1);
         if (pulse_at >= 0)
            ch1_tx_done = (i == pulse_at);
         if (s_tready)
            i++;
         @(negedge clk);
         cyc++;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (pulse_at >= 0)
         ch1_tx_done = 1'b0;
      check("fill_count", 64'(i), 64'(n));
   endtask

   task automatic pulse();
      ch1_tx_done = 1'b1;
      @(negedge clk);
      ch1_tx_done = 1'b0;
   endtask

   // Collect one replayed frame, checking data, tlast, tstrb and hold.
   task automatic drain(input int nexp, input bit incr, input bit rnd,
                        input logic [31:0] cval);
      int          beats = 0;
      int          cyc   = 0;
      bit          fin   = 1'b0;
      bit          hold  = 1'b0;
      logic [31:0] pd;
      logic        pl;
      while (!fin && cyc < 8 * DEPTH) begin
         m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (hold) begin
            check("hold_valid", 64'(m_tvalid), 64'd1);
            check("hold_data", 64'(m_tdata), 64'(pd));
            check("hold_last", 64'(m_tlast), 64'(pl));
         end
         if (m_tvalid && m_tready) begin
            check("beat_data", 64'(m_tdata),
                  incr ? 64'(beats) : 64'(cval));
            check("beat_last", 64'(m_tlast), 64'(beats == nexp - 1));
            check("beat_strb", 64'(m_tstrb), 64'hf);
            beats++;
            fin = m_tlast;
         end
         hold = m_tvalid && !m_tready;
         pd   = m_tdata;
         pl   = m_tlast;
         @(negedge clk);
         cyc++;
      end
      m_tready = 1'b1;
      check("beat_count", 64'(beats), 64'(nexp));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      int mv;

      rst_n       = 1'b0;
      s_tdata     = 32'habcdef01;
      s_tstrb     = 4'h0;
      s_tlast     = 1'b0;
      s_tvalid    = 1'b1;
      m_tready    = 1'b1;
      ch1_tx_done = 1'b0;

      // 1: reset held with input valid
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("rst_s_tready", 64'(s_tready), 64'd0);
         check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      end
      check("rst_m_tdata", 64'(m_tdata), 64'd0);
      check("rst_m_tlast", 64'(m_tlast), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_s_tready", 64'(s_tready), 64'd1);

      // 2: full constant frame, no trigger
      acc = 0;
      mv  = 0;
      for (int c = 0; c < 590; c++) begin
         if (s_tvalid && s_tready)
            acc++;
         if (m_tvalid)
            mv++;
         @(negedge clk);
      end
      check("full_accepted", 64'(acc), 64'd512);
      check("full_s_tready", 64'(s_tready), 64'd0);
      check("full_no_mvalid", 64'(mv), 64'd0);
      s_tvalid = 1'b0;
      repeat (10) @(negedge clk);

      // 3: held-high trigger, latency and full replay
      ch1_tx_done = 1'b1;
      @(negedge clk);
      check("trig_lat1", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      check("trig_lat2", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      check("trig_lat3", 64'(m_tvalid), 64'd1);
      drain(512, 1'b0, 1'b0, 32'habcdef01);
      check("post3_s_tready", 64'(s_tready), 64'd1);
      check("post3_m_tvalid", 64'(m_tvalid), 64'd0);

      // 4: short frame; held level must not replay it
      fill(10, 1'b1, 1'b1, -1);
      mv = 0;
      for (int c = 0; c < 20; c++) begin
         if (m_tvalid)
            mv++;
         @(negedge clk);
      end
      check("no_rereplay", 64'(mv), 64'd0);
      check("wait_s_tready", 64'(s_tready), 64'd0);
      ch1_tx_done = 1'b0;
      @(negedge clk);
      pulse();
      drain(10, 1'b1, 1'b0, 32'h0);
      check("post4_s_tready", 64'(s_tready), 64'd1);

      // 5: same frame with random backpressure
      fill(10, 1'b1, 1'b1, -1);
      pulse();
      drain(10, 1'b1, 1'b1, 32'h0);
      check("post5_s_tready", 64'(s_tready), 64'd1);

      // 6a: trigger remembered from mid-fill
      fill(512, 1'b1, 1'b0, 100);
      check("early_lat1", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      check("early_lat2", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      check("early_lat3", 64'(m_tvalid), 64'd1);
      drain(512, 1'b1, 1'b0, 32'h0);

      // 6b: reset in the middle of a drain
      fill(10, 1'b1, 1'b1, -1);
      pulse();
      m_tready = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_m_tvalid", 64'(m_tvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      check("mid_rst_tdata", 64'(m_tdata), 64'd0);
      check("mid_rst_tlast", 64'(m_tlast), 64'd0);
      check("mid_rst_s_tready", 64'(s_tready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_s_tready", 64'(s_tready), 64'd1);
      fill(3, 1'b1, 1'b1, -1);
      pulse();
      drain(3, 1'b1, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
